md_unit: RTL and testbench



---
 rtl/md_unit_if.sv | 22 ++
 rtl/md_unit.sv | 119 +++++++++++
 tb/tb_md_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - EX-stage multiply/divide unit signal bundle
interface md_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_in_id;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall_req;

  modport master (
    output start, op, a, b, md_in_id,
    input  busy, hi, lo, stall_req
  );

  modport slave (
    input  start, op, a, b, md_in_id,
    output busy, hi, lo, stall_req
  );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit holding HI/LO
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic    clk,
  input  logic    reset_n,
  md_unit_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [31:0]    hi_q, lo_q, hi_nx, lo_nx;
  logic [31:0]    pend_hi, pend_lo, pend_hi_nx, pend_lo_nx;

  // Full-width products: the signed one uses sign-extended operands, whose low 64 bits are exact
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{md.a[31]}}, md.a} * {{32{md.b[31]}}, md.b};
  assign prod_u = {32'd0, md.a} * {32'd0, md.b};

  // Signed division runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  // A zero divisor is swapped for 1 only to keep the divider defined; its result is discarded.
  logic [31:0] mag_a, mag_b, div_s, div_u;
  logic [31:0] uq, ur, sq_mag, sr_mag, sq, sr;
  assign mag_a  = md.a[31] ? (~md.a + 32'd1) : md.a;
  assign mag_b  = md.b[31] ? (~md.b + 32'd1) : md.b;
  assign div_s  = (md.b == 32'd0) ? 32'd1 : mag_b;
  assign div_u  = (md.b == 32'd0) ? 32'd1 : md.b;
  assign uq     = md.a / div_u;
  assign ur     = md.a % div_u;
  assign sq_mag = mag_a / div_s;
  assign sr_mag = mag_a % div_s;
  assign sq     = (md.a[31] ^ md.b[31]) ? (~sq_mag + 32'd1) : sq_mag;
  assign sr     = md.a[31] ? (~sr_mag + 32'd1) : sr_mag;

  // State, countdown, pending result and architectural HI/LO registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      hi_q    <= hi_nx;
      lo_q    <= lo_nx;
      pend_hi <= pend_hi_nx;
      pend_lo <= pend_lo_nx;
    end
  end

  // Accept new ops only when idle; count down while running and commit on the final edge
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    hi_nx      = hi_q;
    lo_nx      = lo_q;
    pend_hi_nx = pend_hi;
    pend_lo_nx = pend_lo;
    case (state)
      IDLE: begin
        if (md.start) begin
          case (md.op)
            3'd0: begin
              {pend_hi_nx, pend_lo_nx} = prod_s;
              cnt_nx   = MULT_N;
              state_nx = RUN;
            end
            3'd1: begin
              {pend_hi_nx, pend_lo_nx} = prod_u;
              cnt_nx   = MULT_N;
              state_nx = RUN;
            end
            3'd2: begin
              pend_hi_nx = (md.b == 32'd0) ? hi_q : sr;
              pend_lo_nx = (md.b == 32'd0) ? lo_q : sq;
              cnt_nx     = DIV_N;
              state_nx   = RUN;
            end
            3'd3: begin
              pend_hi_nx = (md.b == 32'd0) ? hi_q : ur;
              pend_lo_nx = (md.b == 32'd0) ? lo_q : uq;
              cnt_nx     = DIV_N;
              state_nx   = RUN;
            end
            3'd4:    hi_nx = md.a;
            3'd5:    lo_nx = md.a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_nx = cnt - 1'b1;
        if (cnt == 1) begin
          hi_nx    = pend_hi;
          lo_nx    = pend_lo;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign md.busy      = (state == RUN);
  assign md.hi        = hi_q;
  assign md.lo        = lo_q;
  assign md.stall_req = md.md_in_id & (md.busy | (md.start & ~md.op[2]));

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit
module tb_md_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  md_unit_if bus();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md      (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one start pulse for a single cycle
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Issue an op and count busy cycles; flag any HI/LO movement before busy falls
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n, output logic early);
    logic [31:0] h0, l0;
    h0 = bus.hi;
    l0 = bus.lo;
    early = 1'b0;
    drive(op, a, b);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      if (bus.hi !== h0 || bus.lo !== l0) early = 1'b1;
      n++;
      tick();
    end
  endtask

  // Reference: architectural HI/LO after an op, from plain integer arithmetic
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] h,
                                            input logic [31:0] l);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return {h, l};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {h, l};
        return {a % b, a / b};
      end
      3'd4: return {a, l};
      3'd5: return {h, a};
      default: return {h, l};
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic early;
    logic [63:0] r;
    logic [2:0] op;
    logic [31:0] a, b;
    logic seen_busy;

    tv[0] = '{3'd0, 32'hFFFFFFFE, 32'd3,         32'd0,    32'd0,    32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    tv[1] = '{3'd1, 32'hFFFFFFFE, 32'd3,         32'd0,    32'd0,    32'h00000002, 32'hFFFFFFFA, 5};
    tv[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,         32'd0,    32'd0,    32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tv[3] = '{3'd3, 32'd7,        32'd2,         32'd0,    32'd0,    32'd1,        32'd3,        10};
    tv[4] = '{3'd2, 32'd1234,     32'd0,         32'h11,   32'h22,   32'h11,       32'h22,       10};
    tv[5] = '{3'd2, 32'h80000000, 32'hFFFFFFFF,  32'h5,    32'h6,    32'h0,        32'h80000000, 10};
    tv[6] = '{3'd3, 32'hDEAD,     32'd0,         32'hAA,   32'hBB,   32'hAA,       32'hBB,       10};
    tv[7] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,  32'd0,    32'd0,    32'hFFFFFFFE, 32'h00000001, 5};

    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    bus.md_in_id = 1'b0;

    #12;
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Directed vectors: preload HI/LO, run the op, check timing and result
    for (int i = 0; i < 8; i++) begin
      drive(3'd4, tv[i].pre_hi, 32'd0);
      chk($sformatf("v%0d_mthi", i), bus.hi, tv[i].pre_hi);
      drive(3'd5, tv[i].pre_lo, 32'd0);
      chk($sformatf("v%0d_mtlo", i), bus.lo, tv[i].pre_lo);
      run_op(tv[i].op, tv[i].a, tv[i].b, n, early);
      chk($sformatf("v%0d_cycles", i), 32'(n), 32'(tv[i].cyc));
      chk($sformatf("v%0d_hold", i), {31'd0, early}, 32'd0);
      chk($sformatf("v%0d_hi", i), bus.hi, tv[i].exp_hi);
      chk($sformatf("v%0d_lo", i), bus.lo, tv[i].exp_lo);
    end

    // Stall: covers the start cycle and every busy cycle of a mult
    bus.md_in_id = 1'b1;
    bus.start = 1'b1;
    bus.op = 3'd0;
    bus.a = 32'd2;
    bus.b = 32'd3;
    @(negedge clk);
    chk("stall_start", {31'd0, bus.stall_req}, 32'd1);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_busy%0d", i), {31'd0, bus.stall_req}, 32'd1);
      tick();
    end
    @(negedge clk);
    chk("stall_after", {31'd0, bus.stall_req}, 32'd0);
    chk("stall_mult_lo", bus.lo, 32'd6);
    tick();
    bus.start = 1'b1;
    bus.op = 3'd5;
    bus.a = 32'h1234;
    @(negedge clk);
    chk("stall_mtlo", {31'd0, bus.stall_req}, 32'd0);
    tick();
    bus.start = 1'b0;
    bus.md_in_id = 1'b0;
    chk("mtlo_lo", bus.lo, 32'h1234);
    chk("mtlo_busy", {31'd0, bus.busy}, 32'd0);

    // Start while busy: the div is ignored, the mult keeps its schedule
    n = 0;
    drive(3'd0, 32'd7, 32'd9);
    if (bus.busy === 1'b1) n++;
    tick();
    if (bus.busy === 1'b1) n++;
    bus.start = 1'b1;
    bus.op = 3'd2;
    bus.a = 32'd100;
    bus.b = 32'd5;
    tick();
    bus.start = 1'b0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk("ovl_cycles", 32'(n), 32'd5);
    chk("ovl_hi", bus.hi, 32'd0);
    chk("ovl_lo", bus.lo, 32'd63);
    tick();
    chk("ovl_idle", {31'd0, bus.busy}, 32'd0);

    // Asynchronous reset in the middle of a mult
    drive(3'd4, 32'h5555, 32'd0);
    drive(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_hi", bus.hi, 32'd0);
    chk("mid_rst_lo", bus.lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.busy !== 1'b0) seen_busy = 1'b1;
    end
    chk("post_rst_busy", {31'd0, seen_busy}, 32'd0);
    chk("post_rst_lo", bus.lo, 32'd0);
    model_hi = 32'd0;
    model_lo = 32'd0;

    // Random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'd1;
        3: a = 32'h80000000;
        default: ;
      endcase
      r = ref_model(op, a, b, model_hi, model_lo);
      if (op <= 3'd3) begin
        run_op(op, a, b, n, early);
        chk($sformatf("rnd%0d_cycles", i), 32'(n), (op <= 3'd1) ? 32'd5 : 32'd10);
        chk($sformatf("rnd%0d_hold", i), {31'd0, early}, 32'd0);
      end else begin
        drive(op, a, b);
        chk($sformatf("rnd%0d_busy", i), {31'd0, bus.busy}, 32'd0);
      end
      chk($sformatf("rnd%0d_hi", i), bus.hi, r[63:32]);
      chk($sformatf("rnd%0d_lo", i), bus.lo, r[31:0]);
      model_hi = r[63:32];
      model_lo = r[31:0];
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
